// File: rtl/rcosc_timebase_pkg.sv
// Shared types and helpers for the RC-oscillator timebase: alarm state
// encoding, millisecond counter width and prescaler sizing functions.
package rcosc_timebase_pkg;

  // Width of the free-running millisecond counter.
  localparam int MS_COUNT_W = 32;

  // Alarm controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } alarm_state_t;

  // Prescaler modulus: oscillator cycles per microsecond strobe.
  // Returns 0 for a non-positive tick rate so the caller's range check trips.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return (tick_hz > 0) ? (clk_hz / tick_hz) : 0;
  endfunction

  // Bits needed to hold a modulo-n count (0..n-1); never narrower than 1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rcosc_modcnt.sv
// Generic modulo-N counter with count enable, synchronous clear and a
// registered one-cycle wrap strobe. wrap_next is the combinational
// "wrapping on this edge" condition, used to chain counters so a downstream
// stage advances on the very edge this one wraps.
module rcosc_modcnt
  import rcosc_timebase_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_width(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap_next,
  output logic wrap
);

  logic [W-1:0] count_q;
  logic         last;

  assign last      = (count_q == W'(N - 1));
  // Clear takes priority: a cleared counter never reports a wrap.
  assign wrap_next = en && !clr && last;

  // Count register and registered wrap strobe.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= wrap_next;
      if (clr) begin
        count_q <= '0;
      end else if (en) begin
        count_q <= last ? '0 : count_q + W'(1);
      end
    end
  end

endmodule

// File: rtl/rcosc_timebase.sv
// Fabric timebase on the RC oscillator clock: microsecond and millisecond
// one-cycle strobes, a free-running 32-bit millisecond counter and a single
// programmable millisecond alarm with a sticky, acknowledged interrupt.
module rcosc_timebase
  import rcosc_timebase_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1_000_000,
  parameter int US_PER_MS = 1000,
  parameter int ALARM_W   = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic                  CLR,
  output logic                  US_TICK,
  output logic                  MS_TICK,
  output logic [MS_COUNT_W-1:0] MS_COUNT,
  input  logic                  ALARM_LOAD,
  input  logic [ALARM_W-1:0]    ALARM_MS,
  input  logic                  ALARM_ACK,
  output logic                  ALARM_BUSY,
  output logic                  ALARM_IRQ
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int DIV_W = cnt_width(DIV);
  localparam int US_W  = cnt_width(US_PER_MS);

  // Reject parameter sets that cannot produce an exact microsecond strobe.
  if (TICK_HZ <= 0 || (CLK_HZ % TICK_HZ) != 0) begin : g_err_ratio
    $error("rcosc_timebase: CLK_HZ must be an exact multiple of TICK_HZ");
  end
  if (DIV < 2) begin : g_err_div
    $error("rcosc_timebase: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (US_PER_MS < 2) begin : g_err_us
    $error("rcosc_timebase: US_PER_MS must be at least 2");
  end
  if (ALARM_W < 1) begin : g_err_alarm
    $error("rcosc_timebase: ALARM_W must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Prescaler and microsecond counter
  // ---------------------------------------------------------------------------
  logic us_wrap_next;
  logic ms_wrap_next;

  rcosc_modcnt #(
    .N (DIV),
    .W (DIV_W)
  ) u_prescaler (
    .clk       (CLK),
    .rst       (RESET),
    .en        (EN),
    .clr       (CLR),
    .wrap_next (us_wrap_next),
    .wrap      (US_TICK)
  );

  // Advances only on the edge where the prescaler wraps, so its own wrap
  // (and therefore MS_TICK) lines up with a US_TICK.
  rcosc_modcnt #(
    .N (US_PER_MS),
    .W (US_W)
  ) u_us_counter (
    .clk       (CLK),
    .rst       (RESET),
    .en        (us_wrap_next),
    .clr       (CLR),
    .wrap_next (ms_wrap_next),
    .wrap      (MS_TICK)
  );

  // ---------------------------------------------------------------------------
  // Millisecond counter
  // ---------------------------------------------------------------------------
  logic [MS_COUNT_W-1:0] ms_count_q;

  // Increments on the edge that raises MS_TICK; wraps naturally modulo 2^32.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ms_count_q <= '0;
    end else if (CLR) begin
      ms_count_q <= '0;
    end else if (ms_wrap_next) begin
      ms_count_q <= ms_count_q + MS_COUNT_W'(1);
    end
  end

  assign MS_COUNT = ms_count_q;

  // ---------------------------------------------------------------------------
  // Millisecond alarm
  // ---------------------------------------------------------------------------
  alarm_state_t       state_q, state_d;
  logic [ALARM_W-1:0] remain_q, remain_d;
  logic               busy_q, irq_q;

  // Alarm state, remaining interval and registered status flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      remain_q <= '0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      // Flags come from the next state so they change together with it.
      busy_q   <= (state_d == ARMED);
      irq_q    <= (state_d == FIRED);
    end
  end

  // Next-state logic: a load (re)arms from IDLE or ARMED and beats a
  // coincident millisecond tick; FIRED only leaves on acknowledge.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    unique case (state_q)
      IDLE, ARMED: begin
        if (ALARM_LOAD) begin
          if (ALARM_MS == '0) begin
            state_d = FIRED;
          end else begin
            remain_d = ALARM_MS;
            state_d  = ARMED;
          end
        end else if (state_q == ARMED && ms_wrap_next) begin
          if (remain_q == ALARM_W'(1)) begin
            state_d = FIRED;
          end else begin
            remain_d = remain_q - ALARM_W'(1);
          end
        end
      end
      FIRED: begin
        if (ALARM_ACK) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ALARM_BUSY = busy_q;
  assign ALARM_IRQ  = irq_q;

endmodule

// File: tb/tb_rcosc_timebase.sv
// Self-checking bench for rcosc_timebase at DIV=4, US_PER_MS=5. A reference
// model derived from the count of enabled edges pushes the expected strobes
// and millisecond count into a scoreboard every clock; scenario tasks pop and
// compare on the falling edge and add alarm and boundary checks of their own.
module tb_rcosc_timebase;

  localparam int CLK_HZ    = 4_000_000;
  localparam int TICK_HZ   = 1_000_000;
  localparam int US_PER_MS = 5;
  localparam int ALARM_W   = 16;
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int PERIOD    = DIV * US_PER_MS;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               EN;
  logic               CLR;
  logic               US_TICK;
  logic               MS_TICK;
  logic [31:0]        MS_COUNT;
  logic               ALARM_LOAD;
  logic [ALARM_W-1:0] ALARM_MS;
  logic               ALARM_ACK;
  logic               ALARM_BUSY;
  logic               ALARM_IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        us;
    logic        ms;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          m_edges = 0;
  logic [31:0] m_offset = '0;

  rcosc_timebase #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .US_PER_MS (US_PER_MS),
    .ALARM_W   (ALARM_W)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .EN         (EN),
    .CLR        (CLR),
    .US_TICK    (US_TICK),
    .MS_TICK    (MS_TICK),
    .MS_COUNT   (MS_COUNT),
    .ALARM_LOAD (ALARM_LOAD),
    .ALARM_MS   (ALARM_MS),
    .ALARM_ACK  (ALARM_ACK),
    .ALARM_BUSY (ALARM_BUSY),
    .ALARM_IRQ  (ALARM_IRQ)
  );

  always #5 CLK = ~CLK;

  // Reference model: strobes depend only on how many enabled edges have
  // elapsed since the last reset or clear.
  always @(posedge CLK) begin
    if (RESET || CLR) begin
      m_edges <= 0;
      sb_q.push_back(exp_t'({1'b0, 1'b0, 32'd0}));
    end else if (EN) begin
      m_edges <= m_edges + 1;
      sb_q.push_back(exp_t'({((m_edges + 1) % DIV) == 0,
                             ((m_edges + 1) % PERIOD) == 0,
                             m_offset + 32'((m_edges + 1) / PERIOD)}));
    end else begin
      sb_q.push_back(exp_t'({1'b0, 1'b0, m_offset + 32'(m_edges / PERIOD)}));
    end
  end

  // Stimulus only: holds reset over a few edges, then releases it on a
  // falling edge so the next rising edge ends cycle 0.
  task automatic do_reset(input logic en_val);
    RESET      = 1'b1;
    EN         = 1'b0;
    CLR        = 1'b0;
    ALARM_LOAD = 1'b0;
    ALARM_MS   = '0;
    ALARM_ACK  = 1'b0;
    repeat (3) @(negedge CLK);
    m_offset = '0;
    EN       = en_val;
    RESET    = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({US_TICK, MS_TICK, MS_COUNT, ALARM_BUSY, ALARM_IRQ} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_values: got us=%b ms=%b cnt=%h busy=%b irq=%b, want all 0",
               US_TICK, MS_TICK, MS_COUNT, ALARM_BUSY, ALARM_IRQ);
    end
    do_reset(1'b0);
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({US_TICK, MS_TICK, MS_COUNT, ALARM_BUSY, ALARM_IRQ} !== 36'd0) begin
      n_bad++;
      $display("FAIL idle_disabled: got us=%b ms=%b cnt=%h busy=%b irq=%b, want all 0",
               US_TICK, MS_TICK, MS_COUNT, ALARM_BUSY, ALARM_IRQ);
    end
  endtask

  task automatic test_strobes();
    exp_t e;
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge CLK);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL strobes_sb_empty: cycle %0d has no expected entry", cyc);
      end else begin
        e = sb_q.pop_front();
        if ({US_TICK, MS_TICK, MS_COUNT} !== {e.us, e.ms, e.cnt}) begin
          n_bad++;
          $display("FAIL strobes cyc=%0d: got us=%b ms=%b cnt=%0d, want us=%b ms=%b cnt=%0d",
                   cyc, US_TICK, MS_TICK, MS_COUNT, e.us, e.ms, e.cnt);
        end
      end
      if (cyc % PERIOD == 0) begin
        n_cmp++;
        if (MS_TICK !== 1'b1 || US_TICK !== 1'b1 || MS_COUNT !== 32'(cyc / PERIOD)) begin
          n_bad++;
          $display("FAIL ms_tick_cycle cyc=%0d: got us=%b ms=%b cnt=%0d, want us=1 ms=1 cnt=%0d",
                   cyc, US_TICK, MS_TICK, MS_COUNT, cyc / PERIOD);
        end
      end
    end
  endtask

  task automatic test_enable_gap();
    exp_t e;
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge CLK);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL gap_sb_empty: cycle %0d has no expected entry", cyc);
      end else begin
        e = sb_q.pop_front();
        if ({US_TICK, MS_TICK, MS_COUNT} !== {e.us, e.ms, e.cnt}) begin
          n_bad++;
          $display("FAIL gap_strobes cyc=%0d: got us=%b ms=%b cnt=%0d, want us=%b ms=%b cnt=%0d",
                   cyc, US_TICK, MS_TICK, MS_COUNT, e.us, e.ms, e.cnt);
        end
      end
      if (cyc >= 11 && cyc <= 18) begin
        n_cmp++;
        if (US_TICK !== 1'b0) begin
          n_bad++;
          $display("FAIL gap_quiet cyc=%0d: got us=%b, want 0", cyc, US_TICK);
        end
      end
      if (cyc == 19) begin
        n_cmp++;
        if (US_TICK !== 1'b1) begin
          n_bad++;
          $display("FAIL gap_resume cyc=19: got us=%b, want 1", US_TICK);
        end
      end
      EN = !(cyc >= 10 && cyc <= 16);
    end
  endtask

  task automatic test_ms_wrap();
    exp_t e;
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge CLK);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL wrap_sb_empty: cycle %0d has no expected entry", cyc);
      end else begin
        e = sb_q.pop_front();
        if ({US_TICK, MS_TICK, MS_COUNT} !== {e.us, e.ms, e.cnt}) begin
          n_bad++;
          $display("FAIL wrap_strobes cyc=%0d: got us=%b ms=%b cnt=%h, want us=%b ms=%b cnt=%h",
                   cyc, US_TICK, MS_TICK, MS_COUNT, e.us, e.ms, e.cnt);
        end
      end
      if (cyc == 19 || cyc == 20) begin
        n_cmp++;
        if (MS_COUNT !== ((cyc == 19) ? 32'hFFFF_FFFF : 32'h0)) begin
          n_bad++;
          $display("FAIL ms_count_wrap cyc=%0d: got cnt=%h, want %h", cyc, MS_COUNT,
                   (cyc == 19) ? 32'hFFFF_FFFF : 32'h0);
        end
      end
      if (cyc == 5) begin
        force dut.ms_count_q = 32'hFFFF_FFFF;
        m_offset = 32'hFFFF_FFFF - 32'(m_edges / PERIOD);
        #1;
        release dut.ms_count_q;
      end
    end
  endtask

  task automatic test_alarm_basic();
    logic exp_irq;
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 63; cyc++) begin
      @(negedge CLK);
      exp_irq = (cyc >= 3 * PERIOD) && (cyc <= 62);
      n_cmp++;
      if (ALARM_IRQ !== exp_irq || ALARM_BUSY !== (cyc >= 3 && !exp_irq && cyc <= 62)) begin
        n_bad++;
        $display("FAIL alarm_basic cyc=%0d: got busy=%b irq=%b, want busy=%b irq=%b",
                 cyc, ALARM_BUSY, ALARM_IRQ, (cyc >= 3 && !exp_irq && cyc <= 62), exp_irq);
      end
      ALARM_LOAD = (cyc == 2);
      ALARM_MS   = 16'd3;
      ALARM_ACK  = (cyc == 62);
    end
    ALARM_ACK = 1'b0;
  endtask

  task automatic test_alarm_zero();
    @(negedge CLK);
    ALARM_MS   = 16'd0;
    ALARM_LOAD = 1'b1;
    @(negedge CLK);
    ALARM_LOAD = 1'b0;
    n_cmp++;
    if (ALARM_IRQ !== 1'b1 || ALARM_BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL alarm_zero: got busy=%b irq=%b, want busy=0 irq=1", ALARM_BUSY, ALARM_IRQ);
    end
    ALARM_MS   = 16'd4;
    ALARM_LOAD = 1'b1;
    @(negedge CLK);
    ALARM_LOAD = 1'b0;
    n_cmp++;
    if (ALARM_IRQ !== 1'b1 || ALARM_BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL fired_ignores_load: got busy=%b irq=%b, want busy=0 irq=1",
               ALARM_BUSY, ALARM_IRQ);
    end
  endtask

  task automatic test_alarm_reload();
    logic exp_irq;
    logic exp_busy;
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 147; cyc++) begin
      @(negedge CLK);
      exp_irq  = (cyc >= 7 * PERIOD) && (cyc <= 145);
      exp_busy = (cyc >= 3) && (cyc < 7 * PERIOD);
      n_cmp++;
      if (ALARM_IRQ !== exp_irq || ALARM_BUSY !== exp_busy) begin
        n_bad++;
        $display("FAIL alarm_reload cyc=%0d: got busy=%b irq=%b, want busy=%b irq=%b",
                 cyc, ALARM_BUSY, ALARM_IRQ, exp_busy, exp_irq);
      end
      if (cyc == 2 * PERIOD) begin
        n_cmp++;
        if (MS_TICK !== 1'b1) begin
          n_bad++;
          $display("FAIL reload_coincident cyc=%0d: got ms=%b, want 1", cyc, MS_TICK);
        end
      end
      ALARM_LOAD = (cyc == 2) || (cyc == 2 * PERIOD - 1) || (cyc == 145);
      ALARM_MS   = (cyc == 2) ? 16'd3 : 16'd5;
      ALARM_ACK  = (cyc == 145);
    end
    ALARM_LOAD = 1'b0;
    ALARM_ACK  = 1'b0;
  endtask

  task automatic test_reset_clr();
    do_reset(1'b1);
    for (int cyc = 1; cyc <= 69; cyc++) begin
      @(negedge CLK);
      if (cyc >= 3) begin
        n_cmp++;
        if (ALARM_BUSY !== 1'b1 || ALARM_IRQ !== 1'b0) begin
          n_bad++;
          $display("FAIL clr_keeps_alarm cyc=%0d: got busy=%b irq=%b, want busy=1 irq=0",
                   cyc, ALARM_BUSY, ALARM_IRQ);
        end
      end
      if (cyc == 45) begin
        n_cmp++;
        if (MS_COUNT !== 32'd2) begin
          n_bad++;
          $display("FAIL pre_clr_count: got cnt=%0d, want 2", MS_COUNT);
        end
      end
      if (cyc == 46) begin
        n_cmp++;
        if ({US_TICK, MS_TICK, MS_COUNT} !== 34'd0) begin
          n_bad++;
          $display("FAIL clr_zero: got us=%b ms=%b cnt=%0d, want 0 0 0",
                   US_TICK, MS_TICK, MS_COUNT);
        end
      end
      if (cyc == 50) begin
        n_cmp++;
        if (US_TICK !== 1'b1) begin
          n_bad++;
          $display("FAIL clr_prescaler: got us=%b at cycle 50, want 1", US_TICK);
        end
      end
      if (cyc == 66) begin
        n_cmp++;
        if (MS_TICK !== 1'b1 || MS_COUNT !== 32'd1) begin
          n_bad++;
          $display("FAIL post_clr_ms: got ms=%b cnt=%0d, want ms=1 cnt=1", MS_TICK, MS_COUNT);
        end
      end
      ALARM_LOAD = (cyc == 2);
      ALARM_MS   = 16'd10;
      CLR        = (cyc == 45);
    end
    @(posedge CLK);
    #2;
    n_cmp++;
    if (US_TICK !== 1'b1 || MS_COUNT !== 32'd1 || ALARM_BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_async_reset: got us=%b cnt=%0d busy=%b, want us=1 cnt=1 busy=1",
               US_TICK, MS_COUNT, ALARM_BUSY);
    end
    RESET = 1'b1;
    #1;
    n_cmp++;
    if ({US_TICK, MS_TICK, MS_COUNT, ALARM_BUSY, ALARM_IRQ} !== 36'd0) begin
      n_bad++;
      $display("FAIL async_reset: got us=%b ms=%b cnt=%0d busy=%b irq=%b, want all 0",
               US_TICK, MS_TICK, MS_COUNT, ALARM_BUSY, ALARM_IRQ);
    end
    @(negedge CLK);
    RESET = 1'b0;
    EN    = 1'b0;
  endtask

  initial begin
    RESET      = 1'b1;
    EN         = 1'b0;
    CLR        = 1'b0;
    ALARM_LOAD = 1'b0;
    ALARM_MS   = '0;
    ALARM_ACK  = 1'b0;
    test_reset();
    test_strobes();
    test_enable_gap();
    test_ms_wrap();
    test_alarm_basic();
    test_alarm_zero();
    test_alarm_reload();
    test_reset_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
